// File: rtl/three_parallel_serializer.sv
// three_parallel_serializer: buffers 3-lane frames in a 2-deep FIFO and emits them lane by lane, scaled and saturated
module three_parallel_serializer #(
  parameter int IN_W  = 64,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  din0,
  input  logic signed [IN_W-1:0]  din1,
  input  logic signed [IN_W-1:0]  din2,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [OUT_W-1:0] dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic [1:0]              dout_lane,
  output logic                    dout_sat
);
  localparam logic signed [IN_W-1:0] MAX = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] MIN = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  logic signed [IN_W-1:0] r_mem [2][3];
  logic [1:0] r_count;
  logic [1:0] r_lane;
  logic r_wr_ptr;
  logic r_rd_ptr;
  logic w_push;
  logic w_xfer;
  logic w_pop;
  logic w_hi;
  logic w_lo;
  logic signed [IN_W-1:0] w_head;
  logic signed [IN_W-1:0] w_t;
  assign in_ready   = !rst && !r_count[1];
  assign dout_valid = r_count != 2'd0;
  assign w_push     = in_valid && in_ready;
  assign w_xfer     = dout_valid && dout_ready;
  assign w_pop      = w_xfer && r_lane == 2'd2;
  // Select the lane of the head frame that is currently being presented, then scale and clamp it
  always_comb begin
    w_head    = r_lane == 2'd2 ? r_mem[r_rd_ptr][2] : r_lane == 2'd1 ? r_mem[r_rd_ptr][1] : r_mem[r_rd_ptr][0];
    w_t       = w_head >>> SHIFT;
    w_hi      = w_t > MAX;
    w_lo      = w_t < MIN;
    dout      = !dout_valid ? '0 : w_hi ? MAX[OUT_W-1:0] : w_lo ? MIN[OUT_W-1:0] : w_t[OUT_W-1:0];
    dout_sat  = dout_valid && (w_hi || w_lo);
    dout_lane = dout_valid ? r_lane : 2'd0;
  end
  // Frame storage is left unreset; occupancy alone decides what is visible
  always_ff @(posedge clk)
    if (w_push) begin
      r_mem[r_wr_ptr][0] <= din0;
      r_mem[r_wr_ptr][1] <= din1;
      r_mem[r_wr_ptr][2] <= din2;
    end
  // Occupancy, pointers and lane counter; the head frame is released after its last lane leaves
  always_ff @(posedge clk)
    if (rst) begin
      r_count  <= 2'd0;
      r_lane   <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      if (w_xfer) r_lane <= w_pop ? 2'd0 : r_lane + 2'd1;
      r_count <= r_count + 2'(w_push) - 2'(w_pop);
    end
endmodule

// File: tb/tb_three_parallel_serializer.sv
// tb_three_parallel_serializer: sample-queue model plus directed and random stimulus for the serializer
module tb_three_parallel_serializer;
  logic clk = 0;
  logic rst;
  logic signed [63:0] din0, din1, din2;
  logic in_valid;
  logic in_ready;
  logic signed [15:0] dout;
  logic dout_valid;
  logic dout_ready;
  logic [1:0] dout_lane;
  logic dout_sat;
  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;
  typedef struct { longint v; bit s; } samp_t;
  samp_t q[$];

  three_parallel_serializer dut (
    .clk(clk), .rst(rst), .din0(din0), .din1(din1), .din2(din2),
    .in_valid(in_valid), .in_ready(in_ready), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_lane(dout_lane), .dout_sat(dout_sat)
  );

  always #5 clk = ~clk;

  function automatic samp_t scale(longint x);
    samp_t s;
    longint t;
    t = x >>> 15;
    s.s = t > 32767 || t < -32768;
    s.v = t > 32767 ? 32767 : t < -32768 ? -32768 : t;
    return s;
  endfunction

  function automatic void cmp(string nm, longint act, longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endfunction

  // Model: a flat queue of expected output samples; frames outstanding = ceil(samples/3)
  always @(posedge clk) begin
    bit acc;
    if (rst) q.delete();
    else begin
      acc = in_valid && (q.size() + 2) / 3 < 2;
      if (dout_ready && q.size() != 0) void'(q.pop_front());
      if (acc) begin
        q.push_back(scale(din0));
        q.push_back(scale(din1));
        q.push_back(scale(din2));
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    int n;
    if (chk_en) begin
      n = q.size();
      cmp("in_ready", longint'(in_ready), longint'(!rst && (n + 2) / 3 < 2));
      cmp("dout_valid", longint'(dout_valid), longint'(n != 0));
      if (n != 0) begin
        cmp("dout", dout, q[0].v);
        cmp("dout_lane", longint'(dout_lane), longint'((3 - n % 3) % 3));
        cmp("dout_sat", longint'(dout_sat), longint'(q[0].s));
      end else begin
        cmp("dout_idle", dout, 0);
        cmp("dout_lane_idle", longint'(dout_lane), 0);
        cmp("dout_sat_idle", longint'(dout_sat), 0);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_frame(longint a, longint b, longint c);
    din0 = a;
    din1 = b;
    din2 = c;
  endtask

  function automatic longint rnd();
    return $signed({$urandom(), $urandom()}) >>> $urandom_range(20, 63);
  endfunction

  initial begin
    longint e_basic[3];
    longint e_sat[3];
    longint e_satf[3];
    longint big;
    longint k;
    bit r;
    e_basic = '{1, 2, -1};
    e_sat = '{32767, -32768, -1};
    e_satf = '{1, 1, 0};
    big = longint'(1) << 40;
    rst = 1; in_valid = 0; dout_ready = 0;
    set_frame(0, 0, 0);
    step();
    chk_en = 1;
    @(negedge clk);
    cmp("lit_rst_in_ready", longint'(in_ready), 0);
    cmp("lit_rst_dout_valid", longint'(dout_valid), 0);
    step();
    rst = 0;
    @(negedge clk);
    cmp("lit_post_rst_in_ready", longint'(in_ready), 1);
    cmp("lit_post_rst_dout", dout, 0);
    // basic order
    dout_ready = 1; in_valid = 1;
    set_frame(32768, 65536, -32768);
    step();
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp("lit_basic_dout", dout, e_basic[i]);
      cmp("lit_basic_lane", longint'(dout_lane), i);
      step();
    end
    @(negedge clk);
    cmp("lit_basic_done_valid", longint'(dout_valid), 0);
    // saturation
    in_valid = 1;
    set_frame(big, -big, -1);
    step();
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      cmp("lit_sat_dout", dout, e_sat[i]);
      cmp("lit_sat_flag", longint'(dout_sat), e_satf[i]);
      step();
    end
    // back-pressure
    dout_ready = 0; in_valid = 1;
    set_frame(1 * 32768, 2 * 32768, 3 * 32768);
    step();
    set_frame(4 * 32768, 5 * 32768, 6 * 32768);
    step();
    in_valid = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      cmp("lit_bp_in_ready", longint'(in_ready), 0);
      cmp("lit_bp_hold_dout", dout, 1);
      cmp("lit_bp_hold_lane", longint'(dout_lane), 0);
      step();
    end
    dout_ready = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cmp("lit_bp_seq", dout, i + 1);
      step();
    end
    // streaming
    k = 1; in_valid = 1;
    set_frame(k * 98304, k * 98304 + 32768, k * 98304 + 65536);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      r = in_ready;
      if (i > 0) cmp("lit_stream_valid", longint'(dout_valid), 1);
      step();
      if (r) begin
        k++;
        set_frame(k * 98304, k * 98304 + 32768, k * 98304 + 65536);
      end
    end
    in_valid = 0;
    for (int i = 0; i < 8; i++) step();
    // reset mid-frame
    dout_ready = 0; in_valid = 1;
    set_frame(10 * 32768, 11 * 32768, 12 * 32768);
    step();
    set_frame(13 * 32768, 14 * 32768, 15 * 32768);
    step();
    in_valid = 0; dout_ready = 1;
    step();
    step();
    rst = 1;
    @(negedge clk);
    cmp("lit_midrst_in_ready", longint'(in_ready), 0);
    step();
    rst = 0;
    @(negedge clk);
    cmp("lit_midrst_valid", longint'(dout_valid), 0);
    cmp("lit_midrst_in_ready1", longint'(in_ready), 1);
    in_valid = 1;
    set_frame(7 * 32768, 8 * 32768, 9 * 32768);
    step();
    in_valid = 0;
    @(negedge clk);
    cmp("lit_midrst_new_dout", dout, 7);
    cmp("lit_midrst_new_lane", longint'(dout_lane), 0);
    // random traffic
    for (int i = 0; i < 10000; i++) begin
      in_valid = 1'($urandom() % 2);
      dout_ready = 1'($urandom() % 2);
      set_frame(rnd(), rnd(), rnd());
      step();
    end
    in_valid = 0; dout_ready = 1;
    for (int i = 0; i < 8; i++) step();
    @(negedge clk);
    cmp("lit_drain_valid", longint'(dout_valid), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/three_parallel_serializer.md
THREE_PARALLEL_SERIALIZER -- requirements
Module: three_parallel_serializer

Interface
REQ-001 Parameter IN_W, default 64, width of each parallel filter output lane.
REQ-002 Parameter OUT_W, default 16, width of the serial output sample.
REQ-003 Parameter SHIFT, default 15, arithmetic right-shift applied before saturation; legal range 0..IN_W-1.
REQ-004 The block SHALL use a single clock and a synchronous, active-high reset.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 din0  input  IN_W signed  lane 0 of a frame; oldest sample in time.
REQ-008 din1  input  IN_W signed  lane 1 of a frame.
REQ-009 din2  input  IN_W signed  lane 2 of a frame; newest sample in time.
REQ-010 in_valid  input  1  frame on din0..din2 is valid.
REQ-011 in_ready  output  1  block can accept a frame this cycle.
REQ-012 dout  output  OUT_W signed  serial output sample.
REQ-013 dout_valid  output  1  dout holds a valid sample.
REQ-014 dout_ready  input  1  downstream accepts dout this cycle.
REQ-015 dout_lane  output  2  lane index (0..2) of the current dout.
REQ-016 dout_sat  output  1  current dout was clamped by saturation.

Function
REQ-017 Frame accept: the frame SHALL be written to a 2-entry frame FIFO on a rising edge with in_valid=1 and in_ready=1.
REQ-018 in_ready SHALL be 1 exactly when the FIFO count is less than 2 and rst=0; it SHALL depend only on registered state, with no combinational path from dout_ready or in_valid.
REQ-019 Serial order: for each frame, the block SHALL emit lane 0, lane 1, then lane 2, then the next frame's lane 0, with no gaps while dout_ready=1 and the FIFO is non-empty.
REQ-020 dout_valid SHALL equal (FIFO count != 0).
REQ-021 dout, dout_lane and dout_sat SHALL be combinational from the FIFO head entry and the registered lane counter.
REQ-022 Latency: a frame accepted at edge N SHALL present lane 0 with dout_valid=1 in the cycle after edge N when the FIFO was empty.
REQ-023 Output transfer: the transfer SHALL occur on an edge with dout_valid=1 and dout_ready=1; the lane counter then advances 0->1->2->0.
REQ-024 Frame release: on the transfer of lane 2, the head entry SHALL be popped and the lane counter SHALL return to 0.
REQ-025 Stall: while dout_ready=0, dout, dout_lane, dout_sat and dout_valid SHALL hold stable.
REQ-026 Simultaneous push and pop of the last lane SHALL leave the count unchanged and advance both pointers.
REQ-027 Full FIFO: when full, in_ready=0 even if the lane-2 pop happens in the same cycle; in_ready rises the following cycle.
REQ-028 The write and read pointers SHALL be 1 bit each and wrap 1->0.
REQ-029 Arithmetic: the block SHALL compute t = lane >>> SHIFT (sign-preserving, floor).
REQ-030 Saturation: dout SHALL be 2^(OUT_W-1)-1 when t exceeds it, -2^(OUT_W-1) when t is below it, and t[OUT_W-1:0] otherwise.
REQ-031 dout_sat SHALL be 1 when either saturation limit was applied.
REQ-032 When dout_valid=0, dout, dout_lane and dout_sat SHALL be 0.

Reset
REQ-033 With rst=1 at an edge, the block SHALL clear the FIFO count, both pointers and the lane counter to 0.
REQ-034 After reset, dout_valid=0, dout=0, dout_lane=0 and dout_sat=0.
REQ-035 in_ready SHALL be 0 while rst=1 and 1 in the first cycle after rst deasserts.
REQ-036 Reset asserted mid-frame SHALL discard all buffered frames and partial lanes; no stale sample may appear after reset.
REQ-037 FIFO storage contents need not be reset.

Verification
REQ-038 Basic order: one frame din0=32768, din1=65536, din2=-32768, dout_ready=1 -> dout 1, 2, -1 on three consecutive cycles with dout_lane 0, 1, 2, then dout_valid=0.
REQ-039 Saturation: din0=2^40, din1=-2^40, din2=-1 -> dout 32767 (sat=1), -32768 (sat=1), -1 (sat=0).
REQ-040 Back-pressure: two frames pushed, then dout_ready=0 for 5 cycles -> in_ready=0, dout held on lane 0 of frame 1; then dout_ready=1 -> 6 samples in order, no loss or duplication.
REQ-041 Streaming: in_valid=1 continuously with a new frame each time in_ready=1, dout_ready=1 -> continuous dout_valid=1; the frame sequence matches input; in_ready=0 exactly in the cycle after the FIFO reaches 2.
REQ-042 Reset mid-frame: rst pulsed for 1 cycle after lane 1 of a 2-frame backlog -> next cycle dout_valid=0 and count=0; a new frame then emerges starting at lane 0.
REQ-043 Random: constrained-random in_valid/dout_ready at 50% each for 10k cycles against a reference model -> exact sample, lane and sat match, and every accepted frame is emitted.
